// File: rtl/apb_prio_intc_pkg.sv
// rtl/apb_prio_intc_pkg.sv - shared state type and register-map helpers for apb_prio_intc
package intc_pkg;

  typedef enum logic [1:0] {IDLE, ARB, WAIT} state_t;

  localparam int CFG_BASE = 0;

  function automatic int thresh_addr(input int num_src);
    return CFG_BASE + num_src;
  endfunction

  function automatic int en_bit(input int prio_w);
    return prio_w;
  endfunction

endpackage

// File: rtl/apb_prio_intc_if.sv
// rtl/apb_prio_intc_if.sv - APB register bus bundle for apb_prio_intc
interface apb_prio_intc_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 5
) ();
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              perror;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, perror
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, perror
  );
endinterface

// File: rtl/apb_prio_intc_prio_arbiter.sv
// rtl/apb_prio_intc_prio_arbiter.sv - combinational max-priority picker, lowest index wins ties
module prio_arbiter #(
  parameter int NUM_SRC = 16,
  parameter int PRIO_W  = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]        elig_i,
  input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
  output logic                      any_o,
  output logic [IDX_W-1:0]          win_idx_o
);

  logic [PRIO_W-1:0] best;

  // Strict compare while scanning upward keeps the lowest index on equal priority.
  always_comb begin
    any_o     = 1'b0;
    win_idx_o = '0;
    best      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig_i[i] && (!any_o || prio_i[i*PRIO_W +: PRIO_W] > best)) begin
        any_o     = 1'b1;
        best      = prio_i[i*PRIO_W +: PRIO_W];
        win_idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_prio_intc.sv
// rtl/apb_prio_intc.sv - APB-programmable priority interrupt controller with valid/serviced grant handshake
module apb_prio_intc
  import intc_pkg::*;
#(
  parameter int NUM_SRC = 16,
  parameter int PRIO_W  = 4,
  parameter int IDX_W   = $clog2(NUM_SRC),
  parameter int ADDR_W  = IDX_W + 1
) (
  input  logic               pclk,
  input  logic               prst,
  apb_prio_intc_if.slave     apb,
  input  logic [NUM_SRC-1:0] intr_active_i,
  output logic               intr_valid_o,
  output logic [IDX_W-1:0]   intr_id_o,
  input  logic               intr_serviced_i
);

  localparam int                EN       = en_bit(PRIO_W);
  localparam logic [ADDR_W-1:0] THRESH_A = ADDR_W'(thresh_addr(NUM_SRC));

  logic [NUM_SRC-1:0]        cfg_en;
  logic [PRIO_W-1:0]         cfg_prio [NUM_SRC];
  logic [PRIO_W-1:0]         thresh;
  logic                      access, is_cfg, is_thr, legal;
  logic [IDX_W-1:0]          cfg_idx;
  logic [NUM_SRC-1:0]        elig;
  logic [NUM_SRC*PRIO_W-1:0] prio_flat;
  logic                      any;
  logic [IDX_W-1:0]          win_idx;
  state_t                    state, state_n;
  logic                      valid_n;
  logic [IDX_W-1:0]          id_n;

  assign access  = apb.psel & apb.penable;
  assign is_cfg  = apb.paddr < THRESH_A;
  assign is_thr  = apb.paddr == THRESH_A;
  assign legal   = is_cfg | is_thr;
  assign cfg_idx = apb.paddr[IDX_W-1:0];

  assign apb.pready = access & ~prst;
  assign apb.perror = access & ~legal & ~prst;

  always_comb begin
    apb.prdata = '0;
    if (!prst && access) begin
      if (is_cfg)      apb.prdata = {cfg_en[cfg_idx], cfg_prio[cfg_idx]};
      else if (is_thr) apb.prdata = {1'b0, thresh};
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      cfg_en <= '0;
      for (int i = 0; i < NUM_SRC; i++) cfg_prio[i] <= '0;
      thresh <= '0;
    end else if (access && apb.pwrite) begin
      if (is_cfg) begin
        cfg_en[cfg_idx]   <= apb.pwdata[EN];
        cfg_prio[cfg_idx] <= apb.pwdata[PRIO_W-1:0];
      end else if (is_thr) begin
        thresh <= apb.pwdata[PRIO_W-1:0];
      end
    end
  end

  always_comb begin
    elig      = '0;
    prio_flat = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = intr_active_i[i] & cfg_en[i] & (cfg_prio[i] > thresh);
      prio_flat[i*PRIO_W +: PRIO_W] = cfg_prio[i];
    end
  end

  prio_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W), .IDX_W(IDX_W)) u_arb (
    .elig_i    (elig),
    .prio_i    (prio_flat),
    .any_o     (any),
    .win_idx_o (win_idx)
  );

  always_ff @(posedge pclk) begin
    if (prst) begin
      state        <= IDLE;
      intr_valid_o <= 1'b0;
      intr_id_o    <= '0;
    end else begin
      state        <= state_n;
      intr_valid_o <= valid_n;
      intr_id_o    <= id_n;
    end
  end

  // WAIT ignores requests and register writes so the presented grant never shifts under the handler.
  always_comb begin
    state_n = state;
    valid_n = intr_valid_o;
    id_n    = intr_id_o;
    case (state)
      IDLE: if (any) state_n = ARB;
      ARB: begin
        if (any) begin
          id_n    = win_idx;
          valid_n = 1'b1;
          state_n = WAIT;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (intr_serviced_i) begin
          valid_n = 1'b0;
          state_n = any ? ARB : IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_prio_intc.sv
// tb/tb_apb_prio_intc.sv - self-checking bench for apb_prio_intc
module tb_apb_prio_intc;

  logic        pclk = 1'b0;
  logic        prst;
  logic [15:0] intr_active;
  logic        intr_valid;
  logic [3:0]  intr_id;
  logic        intr_serviced;

  apb_prio_intc_if #(.ADDR_W(5), .DATA_W(5)) apb ();

  apb_prio_intc #(.NUM_SRC(16), .PRIO_W(4)) dut (
    .pclk            (pclk),
    .prst            (prst),
    .apb             (apb),
    .intr_active_i   (intr_active),
    .intr_valid_o    (intr_valid),
    .intr_id_o       (intr_id),
    .intr_serviced_i (intr_serviced)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [4:0] wdata;
    logic       chk_rd;
    logic [4:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void add(input logic wr, input logic [4:0] addr, input logic [4:0] wdata,
                              input logic chk_rd, input logic [4:0] exp_rd, input logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  task automatic apb_xfer(input logic wr, input logic [4:0] addr, input logic [4:0] wd,
                          output logic [4:0] rd, output logic err, output logic rdy);
    @(negedge pclk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = addr; apb.pwdata = wd;
    @(negedge pclk);
    apb.penable = 1'b1;
    #1;
    rd = apb.prdata; err = apb.perror; rdy = apb.pready;
    @(negedge pclk);
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic apb_wr(input logic [4:0] addr, input logic [4:0] wd);
    logic [4:0] rd; logic err, rdy;
    apb_xfer(1'b1, addr, wd, rd, err, rdy);
  endtask

  task automatic wait_grant(input string name, input logic [3:0] exp_id);
    for (int c = 0; c < 20; c++) begin
      @(posedge pclk); #1;
      if (intr_valid) break;
    end
    check({name, "_valid"}, intr_valid, 1);
    check({name, "_id"}, intr_id, exp_id);
  endtask

  task automatic no_grant(input string name, input int cycles);
    logic seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge pclk); #1;
      if (intr_valid) seen = 1'b1;
    end
    check(name, seen, 0);
  endtask

  task automatic service(input string name, input logic [15:0] act_after);
    @(negedge pclk);
    intr_serviced = 1'b1;
    intr_active   = act_after;
    @(posedge pclk); #1;
    check(name, intr_valid, 0);
    @(negedge pclk);
    intr_serviced = 1'b0;
  endtask

  initial begin
    logic [4:0] rd; logic err, rdy;

    prst = 1'b1; intr_active = '0; intr_serviced = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk) prst = 1'b0;
    #1;
    check("rst_valid", intr_valid, 0);
    check("rst_id", intr_id, 0);

    for (int a = 0; a <= 16; a++) begin
      apb_xfer(1'b0, 5'(a), '0, rd, err, rdy);
      check($sformatf("rst_rd%0d", a), rd, 0);
      check($sformatf("rst_err%0d", a), err, 0);
    end

    add(0, 5'd17, 5'h00, 1, 5'h00, 1);
    add(0, 5'd31, 5'h00, 1, 5'h00, 1);
    add(1, 5'd17, 5'h1F, 0, 5'h00, 1);
    add(0, 5'd16, 5'h00, 1, 5'h00, 0);
    add(1, 5'd3,  5'h15, 0, 5'h00, 0);
    add(0, 5'd3,  5'h00, 1, 5'h15, 0);
    add(1, 5'd9,  5'h1C, 0, 5'h00, 0);
    add(0, 5'd9,  5'h00, 1, 5'h1C, 0);
    add(1, 5'd16, 5'h1F, 0, 5'h00, 0);
    add(0, 5'd16, 5'h00, 1, 5'h0F, 0);
    add(1, 5'd16, 5'h00, 0, 5'h00, 0);
    add(0, 5'd16, 5'h00, 1, 5'h00, 0);
    add(1, 5'd0,  5'h0A, 0, 5'h00, 0);
    add(0, 5'd0,  5'h00, 1, 5'h0A, 0);
    add(1, 5'd0,  5'h00, 0, 5'h00, 0);
    add(0, 5'd0,  5'h00, 1, 5'h00, 0);

    foreach (vecs[i]) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, rdy);
      check($sformatf("vec%0d_ready", i), rdy, 1);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
    end

    // Exact latency and bubble: CFG3={1,5}, CFG9={1,12}
    @(negedge pclk) intr_active = 16'h0208;
    @(posedge pclk); #1;
    check("lat_edge1_valid", intr_valid, 0);
    @(posedge pclk); #1;
    check("lat_edge2_valid", intr_valid, 1);
    check("lat_edge2_id", intr_id, 9);
    @(negedge pclk) begin intr_active = 16'h0008; intr_serviced = 1'b1; end
    @(posedge pclk); #1;
    check("bubble_valid", intr_valid, 0);
    @(negedge pclk) intr_serviced = 1'b0;
    @(posedge pclk); #1;
    check("second_valid", intr_valid, 1);
    check("second_id", intr_id, 3);
    service("svc3", 16'h0000);

    // Tie on equal priority, then disabled source
    apb_wr(5'd3, 5'h00); apb_wr(5'd9, 5'h00);
    apb_wr(5'd2, 5'h17); apb_wr(5'd6, 5'h17);
    @(negedge pclk) intr_active = 16'h0044;
    wait_grant("tie", 2);
    service("svc_tie", 16'h0040);
    wait_grant("tie_next", 6);
    service("svc6", 16'h0000);
    apb_wr(5'd6, 5'h0F);
    @(negedge pclk) intr_active = 16'h0040;
    no_grant("disabled_src", 8);
    @(negedge pclk) intr_active = 16'h0000;

    // Threshold gating is strict
    apb_wr(5'd2, 5'h00); apb_wr(5'd6, 5'h00);
    apb_wr(5'd16, 5'h08); apb_wr(5'd4, 5'h18); apb_wr(5'd5, 5'h19);
    @(negedge pclk) intr_active = 16'h0030;
    wait_grant("thresh", 5);
    service("svc5", 16'h0010);
    no_grant("at_thresh", 5);
    apb_wr(5'd16, 5'h00);
    wait_grant("thresh_lowered", 4);
    service("svc4", 16'h0000);

    // Grant stays frozen during WAIT
    apb_wr(5'd4, 5'h00); apb_wr(5'd7, 5'h1F);
    @(negedge pclk) intr_active = 16'h0020;
    wait_grant("hold", 5);
    @(negedge pclk) intr_active = 16'h0080;
    @(posedge pclk); #1;
    check("hold_drop_valid", intr_valid, 1);
    check("hold_drop_id", intr_id, 5);
    apb_wr(5'd5, 5'h00);
    check("hold_wr_valid", intr_valid, 1);
    check("hold_wr_id", intr_id, 5);
    service("svc_hold", 16'h0080);
    wait_grant("after_hold", 7);

    // Reset mid-grant
    @(negedge pclk) begin
      prst = 1'b1; apb.psel = 1'b1; apb.penable = 1'b1; apb.pwrite = 1'b0; apb.paddr = 5'd17;
    end
    #1;
    check("rst_pready", apb.pready, 0);
    check("rst_perror", apb.perror, 0);
    check("rst_prdata", apb.prdata, 0);
    check("rst_sync_valid", intr_valid, 1);
    @(posedge pclk); #1;
    check("midrst_valid", intr_valid, 0);
    check("midrst_id", intr_id, 0);
    @(negedge pclk) begin prst = 1'b0; apb.psel = 1'b0; apb.penable = 1'b0; end
    no_grant("post_rst", 6);
    apb_xfer(1'b0, 5'd7, '0, rd, err, rdy);
    check("post_rst_cfg7", rd, 0);
    apb_wr(5'd7, 5'h1F);
    wait_grant("reprog", 7);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
